output_deskew_buf: RTL and testbench

//  Sits between the systolic-array result columns and the shift stage. Columns emit

---
 rtl/output_deskew_buf_pkg.sv | 26 ++
 rtl/output_deskew_buf_sync_fifo.sv | 63 ++++++
 rtl/output_deskew_buf.sv | 101 ++++++++++
 tb/tb_output_deskew_buf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/output_deskew_buf_pkg.sv
// Shared configuration for the output deskew buffer: datapath sizes and a count-width helper.
// Optional feature macro: OUTPUT_BUF_BYPASS_EN (empty-FIFO bypass path in output_deskew_buf).
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif
`ifndef PE_DATASIZE
`define PE_DATASIZE 8
`endif
`ifndef ARRAY_COLS
`define ARRAY_COLS 4
`endif
`ifndef OUTBUF_DEPTH
`define OUTBUF_DEPTH 8
`endif

package output_deskew_buf_pkg;
  localparam int COLS_DEF  = `ARRAY_COLS;
  localparam int DW_DEF    = `PE_DATASIZE;
  localparam int DEPTH_DEF = `OUTBUF_DEPTH;
  localparam int ROW_W_DEF = `OUTPUT_BUF_DATASIZE;

  // One extra bit so that a count of exactly DEPTH is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/output_deskew_buf_sync_fifo.sv
// Synchronous FIFO holding aligned result rows; a pop on a full FIFO frees the slot for a same-cycle push.
// Read data is forced to zero while empty.
module sync_fifo
  import output_deskew_buf_pkg::*;
#(
  parameter int WIDTH = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/output_deskew_buf.sv
// Realigns diagonally skewed systolic-array column results into rows and queues them for the shift stage.
// Optional macro OUTPUT_BUF_BYPASS_EN: a row arriving at an empty FIFO is offered combinationally.
module output_deskew_buf
  import output_deskew_buf_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [COLS*DW-1:0]          in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLS*DW-1:0]          out_data,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow
);
  localparam int W = COLS * DW;

  logic [COLS-2:0] vld_q, vld_d;
  logic [W-1:0]    aligned;
  logic            row_valid;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]    fifo_data;
  logic            overflow_q, overflow_d;
`ifdef OUTPUT_BUF_BYPASS_EN
  logic            bypass;
`endif

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign row_valid = vld_q[COLS-2];

  // Lane c arrives c cycles after lane 0, so it waits COLS-1-c cycles to line up with the last lane.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    if (c == COLS-1) begin : g_direct
      assign aligned[c*DW +: DW] = in_data[c*DW +: DW];
    end else begin : g_delay
      localparam int D = COLS - 1 - c;
      logic [DW-1:0] sr_q [D];
      logic [DW-1:0] sr_d [D];
      always_comb begin
        sr_d[0] = in_data[c*DW +: DW];
        for (int k = 1; k < D; k++) sr_d[k] = sr_q[k-1];
      end
      always_ff @(posedge clk) sr_q <= sr_d;
      assign aligned[c*DW +: DW] = sr_q[D-1];
    end
  end

  always_comb begin
`ifdef OUTPUT_BUF_BYPASS_EN
    bypass    = row_valid && fifo_empty;
    out_valid = !fifo_empty || bypass;
    out_data  = bypass ? aligned : fifo_data;
    fifo_push = row_valid && !(bypass && out_ready);
`else
    out_valid = !fifo_empty;
    out_data  = fifo_data;
    fifo_push = row_valid;
`endif
    fifo_pop   = out_ready && !fifo_empty;
    overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (aligned),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_output_deskew_buf.sv
// Scoreboard bench for output_deskew_buf: stimulus skews directed rows across lanes and queues the expected rows,
// a negedge monitor checks every presented row against the queue head.
module tb_output_deskew_buf;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int W     = COLS * DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          full, empty, overflow;
  logic [CW-1:0] count;

  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  hist [COLS];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  output_deskew_buf #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: lane c carries the row whose column-0 lane was driven c cycles ago.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] row, input logic kept);
    for (int k = COLS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = row;
    for (int c = 0; c < COLS; c++) in_data[c*DW +: DW] = hist[c][c*DW +: DW];
    in_valid = v;
    if (v && kept) exp_q.push_back(row);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] mk_row(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Monitor: accepted rows must match the queue head; a stalled row must already be the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_row: got %h, expected no row", out_data);
      end else if (out_ready) begin
        check_output("row", out_data, exp_q.pop_front());
      end else begin
        check_output("stall_data", out_data, exp_q[0]);
      end
    end
  end

  initial begin
    for (int k = 0; k < COLS; k++) hist[k] = '0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_valid", W'(out_valid), '0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_empty", W'(empty), W'(1));
    check_output("rst_full", W'(full), '0);
    check_output("rst_count", W'(count), '0);
    check_output("rst_overflow", W'(overflow), '0);
    rst = 1'b0;

    // Single row: lanes 11,22,33,44 on consecutive cycles; visible 4 cycles after in_valid.
    out_ready = 1'b1;
    apply_stimulus(1'b1, 32'h44332211, 1'b1);
    idle(2);
    check_output("lat_early", W'(out_valid), '0);
    idle(1);
    check_output("lat_valid", W'(out_valid), W'(1));
    check_output("single_data", out_data, 32'h44332211);
    idle(3);

    // Mid-stream reset: one row queued, two in the deskew pipeline; none may emerge.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hDEADBEEF, 1'b1);
    apply_stimulus(1'b1, 32'hCAFEF00D, 1'b1);
    apply_stimulus(1'b1, 32'h12345678, 1'b1);
    idle(1);
    check_output("pre_rst_count", W'(count), W'(1));
    rst = 1'b1;
    exp_q.delete();
    idle(3);
    check_output("midrst_out_valid", W'(out_valid), '0);
    check_output("midrst_out_data", out_data, '0);
    check_output("midrst_empty", W'(empty), W'(1));
    check_output("midrst_count", W'(count), '0);
    check_output("midrst_overflow", W'(overflow), '0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(6);
    check_output("post_rst_valid", W'(out_valid), '0);
    check_output("post_rst_count", W'(count), '0);

    // Streaming: eight back-to-back rows, occupancy never above one.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, mk_row(8'h10 + 8'(i * 4)), 1'b1);
      check_output("stream_count_le1", W'(count > 1), '0);
    end
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_output("stream_count_le1", W'(count > 1), '0);
    end
    check_output("stream_overflow", W'(overflow), '0);

    // Backpressure: eight rows fill the FIFO, the ninth is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, mk_row(8'h40 + 8'(i * 4)), 1'b1);
    apply_stimulus(1'b1, 32'hBADBADBA, 1'b0);
    idle(3);
    check_output("bp_full", W'(full), W'(1));
    check_output("bp_count", W'(count), W'(8));
    check_output("bp_overflow", W'(overflow), W'(1));
    out_ready = 1'b1;
    idle(10);
    check_output("bp_drained_empty", W'(empty), W'(1));
    check_output("bp_overflow_sticky", W'(overflow), W'(1));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_output("bp_overflow_clr", W'(overflow), '0);

    // Full FIFO with a pop in the same cycle as a new row.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, mk_row(8'h80 + 8'(i * 4)), 1'b1);
    idle(3);
    check_output("fp_full", W'(full), W'(1));
    apply_stimulus(1'b1, 32'h0F1E2D3C, 1'b1);
    idle(2);
    out_ready = 1'b1;
    idle(1);
    check_output("fp_count", W'(count), W'(8));
    check_output("fp_full_after", W'(full), W'(1));
    check_output("fp_overflow", W'(overflow), '0);
    idle(12);

    // Hold: out_ready toggles every cycle over 16 rows.
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b0;
      apply_stimulus(1'b1, mk_row(8'hC0 + 8'(i * 2)), 1'b1);
      out_ready = 1'b1;
      idle(1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check_output("final_queue_empty", W'(exp_q.size()), '0);
    check_output("final_empty", W'(empty), W'(1));
    check_output("final_overflow", W'(overflow), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
